// File: rtl/ctrl_fsm_if.sv
// rtl/ctrl_fsm_if.sv - control bundle between the multicycle controller and its datapath
//
// master: controller side (ctrl_fsm) - receives instr/zero/mem_rdy, drives the control lines
// slave : datapath side              - drives instr/zero/mem_rdy, receives the control lines
//   instr[31:0]  current IR contents (opcode [31:26], funct [5:0])
//   zero         ALU equality flag
//   mem_rdy      data-memory ready handshake
//   ir_we, pc_we, npc_sel[1:0], reg_we, reg_dst[1:0], wd_sel[1:0],
//   alu_src, alu_op[2:0], mem_re, mem_we, eop[1:0], state[2:0]
interface ctrl_fsm_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_rdy;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic [2:0]  alu_op;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  eop;
    logic [2:0]  state;

    modport master (
        input  instr, zero, mem_rdy,
        output ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, mem_re, mem_we, eop, state
    );

    modport slave (
        output instr, zero, mem_rdy,
        input  ir_we, pc_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, mem_re, mem_we, eop, state
    );
endinterface

// File: rtl/ctrl_fsm.sv
// rtl/ctrl_fsm.sv - multicycle MIPS-subset control FSM (FETCH/DECODE/EXEC/MEM/WB)
//
// Ports:
//   clk    rising-edge system clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    ctrl_fsm_if.master: instr/zero/mem_rdy in, datapath control lines and debug state out
// The state register is the only storage; every output is decoded from state and instr,
// with zero reaching pc_we only (beq in EXEC).
module ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_instr;

    logic w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_rtype;

    logic       w_ir_we, w_pc_we, w_reg_we, w_mem_re, w_mem_we;
    logic [1:0] w_npc_sel, w_reg_dst, w_wd_sel;

    assign w_op           = bus.instr[31:26];
    assign w_funct        = bus.instr[5:0];
    assign w_unused_instr = ^bus.instr[25:6];

    assign w_addu  = (w_op == 6'b000000) && (w_funct == 6'b100001);
    assign w_subu  = (w_op == 6'b000000) && (w_funct == 6'b100011);
    assign w_jr    = (w_op == 6'b000000) && (w_funct == 6'b001000);
    assign w_ori   = (w_op == 6'b001101);
    assign w_lw    = (w_op == 6'b100011);
    assign w_sw    = (w_op == 6'b101011);
    assign w_beq   = (w_op == 6'b000100);
    assign w_lui   = (w_op == 6'b001111);
    assign w_j     = (w_op == 6'b000010);
    assign w_jal   = (w_op == 6'b000011);
    assign w_rtype = w_addu || w_subu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = S_FETCH;
        w_ir_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_npc_sel = 2'b00;
        w_reg_we  = 1'b0;
        w_reg_dst = 2'b00;
        w_wd_sel  = 2'b00;
        w_mem_re  = 1'b0;
        w_mem_we  = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_ir_we = 1'b1;
                w_pc_we = 1'b1;
                w_next  = S_DECODE;
            end

            S_DECODE: begin
                if (w_j) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b10;
                    w_next    = S_FETCH;
                end else if (w_jal) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b10;
                    w_reg_we  = 1'b1;
                    w_reg_dst = 2'b10;
                    w_wd_sel  = 2'b10;
                    w_next    = S_FETCH;
                end else if (w_jr) begin
                    w_pc_we   = 1'b1;
                    w_npc_sel = 2'b11;
                    w_next    = S_FETCH;
                end else if (w_rtype || w_ori || w_lui || w_lw || w_sw || w_beq) begin
                    w_next = S_EXEC;
                end else begin
                    // illegal encoding: drop it without touching any state
                    w_next = S_FETCH;
                end
            end

            S_EXEC: begin
                if (w_beq) begin
                    w_npc_sel = 2'b01;
                    w_pc_we   = bus.zero;
                    w_next    = S_FETCH;
                end else if (w_lw || w_sw) begin
                    w_next = S_MEM;
                end else if (w_rtype || w_ori || w_lui) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end

            S_MEM: begin
                // strobe stays up for the whole wait; mem_rdy only steers the exit
                w_mem_re = w_lw;
                w_mem_we = w_sw;
                if (!bus.mem_rdy) begin
                    w_next = S_MEM;
                end else if (w_lw) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end

            S_WB: begin
                w_reg_we = 1'b1;
                if (w_rtype) begin
                    w_reg_dst = 2'b01;
                    w_wd_sel  = 2'b00;
                end else if (w_lw) begin
                    w_reg_dst = 2'b00;
                    w_wd_sel  = 2'b01;
                end else begin
                    w_reg_dst = 2'b00;
                    w_wd_sel  = 2'b00;
                end
                w_next = S_FETCH;
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Enables are gated by reset directly so an abort silences them without waiting for a clock.
    assign bus.ir_we   = reset & w_ir_we;
    assign bus.pc_we   = reset & w_pc_we;
    assign bus.reg_we  = reset & w_reg_we;
    assign bus.mem_re  = reset & w_mem_re;
    assign bus.mem_we  = reset & w_mem_we;
    assign bus.npc_sel = w_npc_sel;
    assign bus.reg_dst = w_reg_dst;
    assign bus.wd_sel  = w_wd_sel;
    assign bus.state   = r_state;

    // Operand select, ALU op and extender mode follow the decode in every state.
    always_comb begin
        bus.alu_src = w_ori || w_lui || w_lw || w_sw;

        bus.alu_op = 3'b000;
        if (w_subu || w_beq) begin
            bus.alu_op = 3'b001;
        end else if (w_ori) begin
            bus.alu_op = 3'b010;
        end

        bus.eop = 2'b00;
        if (w_ori) begin
            bus.eop = 2'b01;
        end else if (w_lui) begin
            bus.eop = 2'b10;
        end else if (w_beq) begin
            bus.eop = 2'b11;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb/tb_ctrl_fsm.sv - bench for ctrl_fsm: directed cases plus random instruction stream
module tb_ctrl_fsm;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    ctrl_fsm_if bus ();

    ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL, C_ILL} cls_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic cls_t cls_of(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op == 6'd0) begin
            if (fn == 6'd33) return C_ADDU;
            if (fn == 6'd35) return C_SUBU;
            if (fn == 6'd8)  return C_JR;
            return C_ILL;
        end
        case (op)
            6'd13:   return C_ORI;
            6'd35:   return C_LW;
            6'd43:   return C_SW;
            6'd4:    return C_BEQ;
            6'd15:   return C_LUI;
            6'd2:    return C_J;
            6'd3:    return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    // cycles from FETCH back to FETCH
    function automatic int latency(input cls_t c, input int w);
        case (c)
            C_J, C_JAL, C_JR, C_ILL: return 2;
            C_BEQ:                   return 3;
            C_SW:                    return 4 + w;
            C_LW:                    return 5 + w;
            default:                 return 4;
        endcase
    endfunction

    // state occupied on the k-th cycle of an instruction
    function automatic int state_at(input cls_t c, input int w, input int k);
        if (k < 3) return k;
        if (c == C_LW || c == C_SW) return (k <= 3 + w) ? 3 : 4;
        return 4;
    endfunction

    // {mask, value} for the packed output word
    function automatic logic [39:0] expect_word(input cls_t c, input int st, input bit z);
        logic       ir, pc, rw, mre, mwe, asrc;
        logic [1:0] npc, rd, ws, eop, npc_m, rw_m;
        logic [2:0] aop;
        logic       exec_m;
        logic       jump;
        logic [19:0] v, m;
        jump  = (c == C_J) || (c == C_JAL) || (c == C_JR);
        ir    = (st == 0);
        pc    = (st == 0) || (st == 1 && jump) || (st == 2 && c == C_BEQ && z);
        npc   = 2'b00;
        if (st == 1 && (c == C_J || c == C_JAL)) npc = 2'b10;
        if (st == 1 && c == C_JR)                npc = 2'b11;
        if (st == 2 && c == C_BEQ)               npc = 2'b01;
        npc_m = ((st == 0) || (st == 1 && jump) || (st == 2 && c == C_BEQ)) ? 2'b11 : 2'b00;
        rw    = (st == 1 && c == C_JAL) || (st == 4);
        rd    = (c == C_JAL) ? 2'b10 : (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
        ws    = (c == C_JAL) ? 2'b10 : (c == C_LW) ? 2'b01 : 2'b00;
        rw_m  = rw ? 2'b11 : 2'b00;
        asrc  = (c == C_ORI) || (c == C_LUI) || (c == C_LW) || (c == C_SW);
        aop   = (c == C_SUBU || c == C_BEQ) ? 3'b001 : (c == C_ORI) ? 3'b010 : 3'b000;
        exec_m = (st == 2);
        mre   = (st == 3) && (c == C_LW);
        mwe   = (st == 3) && (c == C_SW);
        eop   = (c == C_ORI) ? 2'b01 : (c == C_LUI) ? 2'b10 : (c == C_BEQ) ? 2'b11 : 2'b00;
        v = {ir, pc, npc, rw, rd, ws, asrc, aop, mre, mwe, eop, 3'(st)};
        m = {1'b1, 1'b1, npc_m, 1'b1, rw_m, rw_m, exec_m, {3{exec_m}}, 1'b1, 1'b1, 2'b11, 3'b111};
        return {m, v};
    endfunction

    function automatic logic [19:0] obs_word();
        return {bus.ir_we, bus.pc_we, bus.npc_sel, bus.reg_we, bus.reg_dst, bus.wd_sel,
                bus.alu_src, bus.alu_op, bus.mem_re, bus.mem_we, bus.eop, bus.state};
    endfunction

    function automatic logic [4:0] enables();
        return {bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_re, bus.mem_we};
    endfunction

    // Runs one instruction starting just after a rising edge; abort_k >= 0 pulls reset on that cycle.
    task automatic run_instr(input logic [31:0] ins, input int w, input bit z, input int abort_k);
        cls_t        c;
        int          len;
        int          st;
        logic [39:0] e;
        c   = cls_of(ins);
        len = latency(c, w);
        for (int k = 0; k < len; k++) begin
            st = state_at(c, w, k);
            bus.instr   = ins;
            bus.zero    = (st == 2 && c == C_BEQ) ? z : 1'($urandom);
            bus.mem_rdy = (st == 3) ? ((k - 3) == w) : 1'($urandom);
            @(negedge clk);
            e = expect_word(c, st, z);
            check_val($sformatf("ins=%h k=%0d", ins, k), 32'(obs_word() & e[39:20]),
                      32'(e[19:0] & e[39:20]));
            if (k == abort_k) begin
                #2 reset = 1'b0;
                #1;
                check_val("abort_state", 32'(bus.state), 32'd0);
                check_val("abort_mem_we", 32'(bus.mem_we), 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    check_val("rst_enables", 32'(enables()), 32'd0);
                    check_val("rst_state", 32'(bus.state), 32'd0);
                end
                @(posedge clk);
                #1 reset = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_val($sformatf("ret ins=%h", ins), 32'(bus.state), 32'd0);
    endtask

    function automatic logic [31:0] rand_instr(input int sel);
        logic [31:0] r;
        logic [5:0]  op;
        logic [5:0]  fn;
        r = $urandom;
        case (sel)
            0:  return {6'd0, r[25:6], 6'd33};
            1:  return {6'd0, r[25:6], 6'd35};
            2:  return {6'd0, r[25:6], 6'd8};
            3:  return {6'd13, r[25:0]};
            4:  return {6'd35, r[25:0]};
            5:  return {6'd43, r[25:0]};
            6:  return {6'd4, r[25:0]};
            7:  return {6'd15, r[25:0]};
            8:  return {6'd2, r[25:0]};
            9:  return {6'd3, r[25:0]};
            10: begin
                fn = r[5:0];
                while (fn == 6'd33 || fn == 6'd35 || fn == 6'd8) fn = 6'($urandom);
                return {6'd0, r[25:6], fn};
            end
            default: begin
                op = r[31:26];
                while (op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd13, 6'd15, 6'd35, 6'd43})
                    op = 6'($urandom);
                return {op, r[25:0]};
            end
        endcase
    endfunction

    initial begin
        bus.instr   = 32'h0085_3021;
        bus.zero    = 1'b0;
        bus.mem_rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_val("reset_enables", 32'(enables()), 32'd0);
            check_val("reset_state", 32'(bus.state), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(32'h0085_3021, 0, 1'b0, -1);
        run_instr(32'h8C82_0004, 2, 1'b0, -1);
        run_instr(32'h1085_0003, 0, 1'b1, -1);
        run_instr(32'h1085_0003, 0, 1'b0, -1);
        run_instr(32'h0C00_0010, 0, 1'b0, -1);
        run_instr(32'h3C01_1234, 0, 1'b0, -1);
        run_instr(32'h3421_1234, 0, 1'b0, -1);
        run_instr(32'hFC00_0000, 0, 1'b0, -1);
        run_instr(32'hAC82_0008, 1, 1'b0, -1);
        run_instr(32'hAC82_0008, 5, 1'b0, 4);
        run_instr(32'h0085_3023, 0, 1'b0, -1);

        for (int i = 0; i < 80; i++) begin
            run_instr(rand_instr(int'($urandom_range(0, 11))), int'($urandom_range(0, 3)),
                      1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
